// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-drain UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam int unsigned DATA_BITS     = 8;
  localparam logic        TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: ticks on the last clock of each UART bit.
module uart_baud_tick
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == LastCnt)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LastCnt);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO read port and serialises each one as a UART frame.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rden,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam logic [2:0] LastData  = 3'(DATA_BITS - 1);
  localparam logic [2:0] LastStop  = 3'(STOP_BITS - 1);
  localparam logic       ParityInv = (PARITY_ODD != 0);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 parity_q, parity_d;
  logic                 tick;
  logic                 clr;

  // Every state change restarts the bit period so START always gets a full bit.
  assign clr = (state_d != state_q);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .tick(tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    parity_d  = parity_q;
    case (state_q)
      StIdle: begin
        if (en && !fifo_empty) state_d = StFetch;
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        shift_d  = fifo_data;
        parity_d = (^fifo_data) ^ ParityInv;
        state_d  = StStart;
      end
      StStart: begin
        if (tick) state_d = StData;
      end
      StData: begin
        if (tick) begin
          shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LastData) state_d = (PARITY_EN != 0) ? StParity : StStop;
        end
      end
      StParity: begin
        if (tick) state_d = StStop;
      end
      StStop: begin
        // bit_idx doubles as the stop-bit counter.
        if (tick) begin
          if (bit_idx_q == LastStop) begin
            bit_idx_d = 3'd0;
            state_d   = StIdle;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_idx_q <= 3'd0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      parity_q  <= parity_d;
    end
  end

  always_comb begin
    tx = TX_IDLE_LEVEL;
    case (state_q)
      StStart:  tx = ~TX_IDLE_LEVEL;
      StData:   tx = shift_q[0];
      StParity: tx = parity_q;
      default:  tx = TX_IDLE_LEVEL;
    endcase
  end

  assign fifo_rden = (state_q == StFetch);
  assign busy      = (state_q != StIdle);
  assign tx_done   = (state_q == StStop) && tick && (bit_idx_q == LastStop);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised and directed checks of fifo_uart_tx against a frame-level line model.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int NI  = 3;
  // Per-instance configuration: A = plain, B = even parity, C = odd parity + 2 stop bits.
  localparam int PE [NI] = '{0, 1, 1};
  localparam int PO [NI] = '{0, 0, 1};
  localparam int SB [NI] = '{1, 1, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en         [NI];
  logic       fifo_empty [NI];
  logic [7:0] fifo_data  [NI];
  logic       fifo_rden  [NI];
  logic       tx         [NI];
  logic       busy       [NI];
  logic       tx_done    [NI];

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  logic [7:0] src [NI][64];
  int wr [NI];
  int rd [NI];
  int rden_cnt [NI];

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .rst(rst), .en(en[0]), .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]),
    .fifo_rden(fifo_rden[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0])
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_b (
    .clk(clk), .rst(rst), .en(en[1]), .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]),
    .fifo_rden(fifo_rden[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1])
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut_c (
    .clk(clk), .rst(rst), .en(en[2]), .fifo_empty(fifo_empty[2]), .fifo_data(fifo_data[2]),
    .fifo_rden(fifo_rden[2]), .tx(tx[2]), .busy(busy[2]), .tx_done(tx_done[2])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFO read port: data appears the cycle after rden is sampled.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (fifo_rden[i] === 1'b1) begin
        fifo_data[i] <= src[i][rd[i]];
        rd[i]        <= rd[i] + 1;
        rden_cnt[i]  <= rden_cnt[i] + 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NI; i++) fifo_empty[i] = (rd[i] >= wr[i]);
  end

  task automatic push(input int i, input logic [7:0] b);
    src[i][wr[i]] = b;
    wr[i] = wr[i] + 1;
  endtask

  function automatic int frame_len(input int i);
    return (1 + 8 + PE[i] + SB[i]) * CPB;
  endfunction

  // Expected line level for bit period 'slot' of a frame carrying byte b.
  function automatic logic exp_bit(input int i, input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (slot == 9 && PE[i] != 0) return (^b) ^ (PO[i] != 0);
    return 1'b1;
  endfunction

  task automatic expect_frame(input int i, input logic [7:0] b, input string name,
                              output int rden_cyc);
    int  waited;
    bit  seen;
    int  len;
    logic eb;
    logic ed;
    waited   = 0;
    seen     = 0;
    rden_cyc = -1;
    len      = frame_len(i);
    while (!seen && waited < 200) begin
      @(negedge clk);
      if (fifo_rden[i] === 1'b1) seen = 1;
      else waited++;
    end
    checks++;
    if (!seen) begin
      $display("FAIL %s_fetch: fifo_rden never seen in 200 cycles, required one pulse", name);
      return;
    end
    if (tx[i] !== 1'b1 || busy[i] !== 1'b1) begin
      $display("FAIL %s_fetch: tx=%b busy=%b, required tx=1 busy=1", name, tx[i], busy[i]);
    end else passes++;
    rden_cyc = cyc;
    @(negedge clk);
    checks++;
    if (tx[i] !== 1'b1 || busy[i] !== 1'b1 || fifo_rden[i] !== 1'b0) begin
      $display("FAIL %s_load: tx=%b busy=%b rden=%b, required 1 1 0", name, tx[i], busy[i],
               fifo_rden[i]);
    end else passes++;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      eb = exp_bit(i, b, c / CPB);
      ed = (c == len - 1);
      checks++;
      if (tx[i] !== eb || tx_done[i] !== ed || busy[i] !== 1'b1 || fifo_rden[i] !== 1'b0) begin
        $display("FAIL %s cyc%0d: tx=%b done=%b busy=%b rden=%b, required tx=%b done=%b busy=1 rden=0",
                 name, c, tx[i], tx_done[i], busy[i], fifo_rden[i], eb, ed);
      end else passes++;
    end
  endtask

  task automatic idle_check(input int i, input int n, input string name);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checks++;
      if (tx[i] !== 1'b1 || busy[i] !== 1'b0 || fifo_rden[i] !== 1'b0 || tx_done[i] !== 1'b0) begin
        $display("FAIL %s: tx=%b busy=%b rden=%b done=%b, required 1 0 0 0", name, tx[i], busy[i],
                 fifo_rden[i], tx_done[i]);
      end else passes++;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NI; i++) en[i] = 1'b0;
    #1 rst = 1'b0;
    push(0, 8'hA5);
    en[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (tx[0] !== 1'b1 || fifo_rden[0] !== 1'b0 || busy[0] !== 1'b0 || tx_done[0] !== 1'b0) begin
        $display("FAIL reset_hold: tx=%b rden=%b busy=%b done=%b, required 1 0 0 0", tx[0],
                 fifo_rden[0], busy[0], tx_done[0]);
      end else passes++;
    end
    rst = 1'b1;
  endtask

  task automatic test_single_byte();
    int t;
    expect_frame(0, 8'hA5, "single_a5", t);
    idle_check(0, 20, "single_idle");
    checks++;
    if (rden_cnt[0] !== 1) $display("FAIL single_pops: got %0d pulses, required 1", rden_cnt[0]);
    else passes++;
  endtask

  task automatic test_parity();
    int t;
    push(1, 8'hA5);
    push(1, 8'h01);
    en[1] = 1'b1;
    expect_frame(1, 8'hA5, "parity_even_a5", t);
    expect_frame(1, 8'h01, "parity_even_01", t);
    push(2, 8'hA5);
    en[2] = 1'b1;
    expect_frame(2, 8'hA5, "parity_odd_a5", t);
    idle_check(2, 4, "parity_idle");
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    push(2, 8'h00);
    push(2, 8'hFF);
    expect_frame(2, 8'h00, "b2b_00", t0);
    idle_check(2, 1, "b2b_gap_idle");
    expect_frame(2, 8'hFF, "b2b_ff", t1);
    checks++;
    if (t1 - t0 !== frame_len(2) + 3) begin
      $display("FAIL b2b_spacing: rden pulses %0d apart, required %0d", t1 - t0, frame_len(2) + 3);
    end else passes++;
  endtask

  task automatic test_random();
    int t;
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom_range(0, 255));
      push(k % 2 + 1, b);
      expect_frame(k % 2 + 1, b, "random", t);
    end
  endtask

  task automatic test_empty_idle();
    int base;
    base = rden_cnt[0];
    en[0] = 1'b1;
    idle_check(0, 100, "empty_idle");
    checks++;
    if (rden_cnt[0] !== base) $display("FAIL empty_pops: got %0d, required %0d", rden_cnt[0], base);
    else passes++;
  endtask

  task automatic test_en_drop();
    int t, base;
    push(0, 8'h3C);
    push(0, 8'h55);
    base = rden_cnt[0];
    fork
      expect_frame(0, 8'h3C, "en_drop_3c", t);
      begin
        repeat (12) @(negedge clk);
        en[0] = 1'b0;
      end
    join
    idle_check(0, 30, "en_drop_idle");
    checks++;
    if (rden_cnt[0] !== base + 1) begin
      $display("FAIL en_drop_pops: got %0d, required %0d", rden_cnt[0], base + 1);
    end else passes++;
  endtask

  task automatic test_reset_mid();
    int  waited;
    bit  seen;
    int  t;
    waited = 0;
    seen   = 0;
    en[0]  = 1'b1;
    while (!seen && waited < 200) begin
      @(negedge clk);
      if (fifo_rden[0] === 1'b1) seen = 1;
      else waited++;
    end
    checks++;
    if (!seen) begin
      $display("FAIL rstmid_fetch: fifo_rden never seen, required one pulse");
    end else passes++;
    // LOAD + START + data bits 0..2, then two cycles into bit 3 (0 for 0x55).
    repeat (19) @(negedge clk);
    checks++;
    if (tx[0] !== 1'b0 || busy[0] !== 1'b1) begin
      $display("FAIL rstmid_bit3: tx=%b busy=%b, required 0 1", tx[0], busy[0]);
    end else passes++;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
      $display("FAIL rstmid_async: tx=%b busy=%b, required 1 0", tx[0], busy[0]);
    end else passes++;
    push(0, 8'h96);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    expect_frame(0, 8'h96, "rstmid_next", t);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_parity();
    test_back_to_back();
    test_random();
    test_empty_idle();
    test_en_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream drain stage for the 32x8 byte FIFO: pops one byte at a time through the FIFO read port and serialises it as an asynchronous UART frame on a single line.
- Sits between the FIFO read side (rden / data_out / empty) and the board-level TX pin.
- Flow control comes only from FIFO empty and a local enable; there is no backpressure from the line.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit (must be >= 2); baud counter width = $clog2(CLKS_PER_BIT).
- PARITY_EN, 0, 1 = insert a parity bit after data bit 7.
- PARITY_ODD, 0, when PARITY_EN = 1: 0 = even parity, 1 = odd parity.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (rst = 0 resets).
- en  input  1  drain enable; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  8  FIFO data_out; valid on the cycle after rden is sampled.
- fifo_rden  output  1  FIFO read strobe; one-cycle pulse per byte.
- tx  output  1  serial line; idle high.
- busy  output  1  high in every state except IDLE.
- tx_done  output  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Reset (rst = 0, async): state = IDLE, tx = 1, fifo_rden = 0, busy = 0, tx_done = 0, baud counter = 0, bit index = 0, shift register = 0.
- All outputs are decoded from registered state, so none is combinational from inputs.
- State machine and transitions:
  - IDLE -> FETCH when en = 1 and fifo_empty = 0.
  - FETCH, 1 cycle: fifo_rden = 1. -> LOAD.
  - LOAD, 1 cycle: capture fifo_data into the shift register and compute parity (XOR of 8 bits, inverted when PARITY_ODD = 1). -> START.
  - START: tx = 0 for CLKS_PER_BIT cycles. -> DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; shift right at each bit end. -> PARITY if PARITY_EN = 1, else -> STOP.
  - PARITY: tx = parity bit for CLKS_PER_BIT cycles. -> STOP.
  - STOP: tx = 1 for STOP_BITS * CLKS_PER_BIT cycles; tx_done pulses on the final cycle. -> IDLE.
- Baud counter counts 0 .. CLKS_PER_BIT-1; the bit ends when count = CLKS_PER_BIT-1, then the counter wraps to 0. Bit index is 3 bits and wraps 7 -> 0 on leaving DATA.
- Frame length: (1 + 8 + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Back-to-back bytes: the IDLE, FETCH and LOAD cycles give exactly 3 tx-high cycles between the stop-bit end and the next start bit.
- fifo_empty is checked only in IDLE. A byte already popped is always transmitted in full.
- en deasserted mid-frame: the current frame completes, then the block stays in IDLE.
- en = 1 with fifo_empty = 1: stay in IDLE; fifo_rden never asserts.
- Reset mid-frame: tx returns high immediately. A byte already popped is lost, and this is accepted.
- At most one fifo_rden pulse per frame; fifo_rden is never asserted outside FETCH.

Decomposition:
- Package fifo_uart_pkg:
  - state enum typedef: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
  - constants: DATA_BITS = 8, TX_IDLE_LEVEL = 1'b1.
- Natural sub-module: uart_baud_tick, a counter with a tick output at CLKS_PER_BIT-1, synchronous clear on state change, and the same async reset.
- FSM and shift register stay in the top.

Test Plan:
- Reset value check: hold rst = 0 with en = 1 and fifo_empty = 0 -> tx = 1, fifo_rden = 0, busy = 0, tx_done = 0 throughout.
- Single byte 0xA5, CLKS_PER_BIT = 4, no parity, 1 stop -> exactly one fifo_rden pulse.
  - tx, 4 cycles per bit: 0 | 1,0,1,0,0,1,0,1 | 1.
  - 40-cycle frame; tx_done pulses once on cycle 40 of the frame.
- Parity: 0xA5 with PARITY_EN = 1 -> parity bit 0 (even) or 1 (PARITY_ODD = 1); 0x01 even -> 1. Frame 44 cycles.
- Back-to-back 0x00 then 0xFF, STOP_BITS = 2 -> 2 fifo_rden pulses 51 cycles apart (48-cycle frame + 3); 8 consecutive tx = 1 cycles followed by 3 tx-high gap cycles between frames.
- fifo_empty = 1 with en = 1 for 100 cycles -> no fifo_rden, busy = 0. Deassert en in the DATA state of 0x3C -> frame completes, then IDLE even though fifo_empty = 0.
- Assert rst = 0 during DATA bit 3 -> tx = 1 and busy = 0 asynchronously. After release, the next byte starts from FETCH with a fresh start bit.
